// File: rtl/rock_pkg.sv
// Shared definitions for the rocking regulator: FSM states and axis/direction codes.
package rock_pkg;

    typedef enum logic [2:0] {
        S_INIT    = 3'd0,
        S_MEAS    = 3'd1,
        S_EVAL    = 3'd2,
        S_STEP    = 3'd3,
        S_RECOVER = 3'd4
    } state_e;

    localparam logic AXIS_FREQ = 1'b0;
    localparam logic AXIS_AMP  = 1'b1;
    localparam logic DIR_UP    = 1'b0;
    localparam logic DIR_DN    = 1'b1;

endpackage

// File: rtl/stress_avg.sv
// Stress accumulator: sums huil_vol + weighted hartslag over 2**AVG_LOG samples
// and flags the sample that completes a window.
module stress_avg #(
    parameter int DATA_W   = 8,
    parameter int AVG_LOG  = 2,
    parameter int HR_SHIFT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr,
    input  logic              add,
    input  logic [DATA_W-1:0] huil_vol,
    input  logic [DATA_W-1:0] hartslag,
    output logic [DATA_W:0]   avg,
    output logic              done
);

    localparam int ACC_W = DATA_W + 1 + AVG_LOG;
    localparam int CNT_W = AVG_LOG + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << AVG_LOG) - 1);

    logic [DATA_W:0]  stress;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // One extra bit keeps the weighted sum from overflowing.
    assign stress = {1'b0, huil_vol} + ({1'b0, hartslag} >> HR_SHIFT);
    assign done   = add && (cnt_q == CNT_LAST);
    assign avg    = acc_q[ACC_W-1:AVG_LOG];

    // Clear wins over accumulate; the counter restarts once a window completes.
    always_comb begin
        acc_d = acc_q;
        cnt_d = cnt_q;
        if (clr) begin
            acc_d = '0;
            cnt_d = '0;
        end else if (add) begin
            acc_d = acc_q + ACC_W'(stress);
            cnt_d = done ? '0 : cnt_q + CNT_W'(1);
        end
    end

    // Accumulator and sample counter registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_q <= '0;
            cnt_q <= '0;
        end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/rock_regulator.sv
// Hill-climb rocking regulator: alternates amp/freq steps, keeps the best averaged
// stress and restarts the search when the path is lost or on external request.
module rock_regulator
    import rock_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int LVL_W      = 3,
    parameter int AVG_LOG    = 2,
    parameter int HR_SHIFT   = 1,
    parameter int MARGIN     = 16,
    parameter int LOST_LIMIT = 4,
    parameter int AMP_INIT   = 3,
    parameter int FREQ_INIT  = 3,
    localparam int LC_W      = $clog2(LOST_LIMIT + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              herstart,
    input  logic              sample_valid,
    input  logic [DATA_W-1:0] huil_vol,
    input  logic [DATA_W-1:0] hartslag,
    output logic [LVL_W-1:0]  amp,
    output logic [LVL_W-1:0]  freq,
    output logic              eval_pulse,
    output logic              restart,
    output logic [LC_W-1:0]   lost_cnt
);

    localparam logic [LVL_W-1:0] LVL_MAX = {LVL_W{1'b1}};

    state_e            state_q, state_d;
    logic [DATA_W:0]   best_q, best_d;
    logic [LVL_W-1:0]  amp_q, amp_d, freq_q, freq_d, lvl;
    logic              axis_q, axis_d, dir_q, dir_d;
    logic [LC_W-1:0]   lost_q, lost_d;
    logic              eval_q, eval_d, restart_q, restart_d;
    logic [DATA_W:0]   avg;
    logic              avg_done, avg_clr, avg_add, worse;

    assign avg_add = sample_valid && (state_q == S_MEAS);
    assign avg_clr = (state_q != S_MEAS) || herstart || !enable;

    stress_avg #(
        .DATA_W  (DATA_W),
        .AVG_LOG (AVG_LOG),
        .HR_SHIFT(HR_SHIFT)
    ) u_avg (
        .clk     (clk),
        .reset   (reset),
        .clr     (avg_clr),
        .add     (avg_add),
        .huil_vol(huil_vol),
        .hartslag(hartslag),
        .avg     (avg),
        .done    (avg_done)
    );

    // Extra headroom bit so best=all-ones plus MARGIN cannot wrap.
    assign worse = {1'b0, avg} > ({1'b0, best_q} + (DATA_W + 2)'(MARGIN));

    // Next-state logic; levels move on entry to S_STEP so a new level shows two
    // cycles after the last sample.
    always_comb begin
        state_d   = state_q;
        best_d    = best_q;
        amp_d     = amp_q;
        freq_d    = freq_q;
        axis_d    = axis_q;
        dir_d     = dir_q;
        lost_d    = lost_q;
        eval_d    = 1'b0;
        restart_d = 1'b0;
        lvl       = '0;
        if (herstart && state_q != S_RECOVER) begin
            state_d = S_RECOVER;
        end else if (!enable) begin
            state_d = S_INIT;
        end else begin
            unique case (state_q)
                S_INIT: state_d = S_MEAS;
                S_MEAS: begin
                    if (avg_done) begin
                        state_d = S_EVAL;
                        eval_d  = 1'b1;
                    end
                end
                S_EVAL: begin
                    if (avg < best_q) begin
                        best_d = avg;
                        lost_d = '0;
                    end else begin
                        dir_d  = ~dir_q;
                        axis_d = ~axis_q;
                        lost_d = worse ? lost_q + LC_W'(1) : '0;
                    end
                    if (lost_d == LC_W'(LOST_LIMIT)) begin
                        state_d = S_RECOVER;
                    end else begin
                        state_d = S_STEP;
                        // Saturated levels bounce back instead of wrapping.
                        lvl = (axis_d == AXIS_AMP) ? amp_q : freq_q;
                        if (dir_d == DIR_UP) begin
                            if (lvl == LVL_MAX) begin
                                lvl   = lvl - LVL_W'(1);
                                dir_d = DIR_DN;
                            end else begin
                                lvl = lvl + LVL_W'(1);
                            end
                        end else begin
                            if (lvl == '0) begin
                                lvl   = lvl + LVL_W'(1);
                                dir_d = DIR_UP;
                            end else begin
                                lvl = lvl - LVL_W'(1);
                            end
                        end
                        if (axis_d == AXIS_AMP) amp_d = lvl;
                        else                    freq_d = lvl;
                    end
                end
                S_STEP:    state_d = S_MEAS;
                S_RECOVER: state_d = S_INIT;
                default:   state_d = S_INIT;
            endcase
        end
        // Everything re-seeds on entry to S_RECOVER so the pulse cycle shows INIT levels.
        if (state_d == S_RECOVER) begin
            restart_d = 1'b1;
            amp_d     = LVL_W'(AMP_INIT);
            freq_d    = LVL_W'(FREQ_INIT);
            best_d    = '1;
            lost_d    = '0;
            axis_d    = AXIS_FREQ;
            dir_d     = DIR_UP;
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_INIT;
            best_q    <= '1;
            amp_q     <= LVL_W'(AMP_INIT);
            freq_q    <= LVL_W'(FREQ_INIT);
            axis_q    <= AXIS_FREQ;
            dir_q     <= DIR_UP;
            lost_q    <= '0;
            eval_q    <= 1'b0;
            restart_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            best_q    <= best_d;
            amp_q     <= amp_d;
            freq_q    <= freq_d;
            axis_q    <= axis_d;
            dir_q     <= dir_d;
            lost_q    <= lost_d;
            eval_q    <= eval_d;
            restart_q <= restart_d;
        end
    end

    assign amp        = amp_q;
    assign freq       = freq_q;
    assign eval_pulse = eval_q;
    assign restart    = restart_q;
    assign lost_cnt   = lost_q;

endmodule

// File: tb/tb_rock_regulator.sv
// Bench for rock_regulator: evaluation-level reference model driven by directed
// and randomized sample windows.
module tb_rock_regulator;

    logic       clk = 1'b0;
    logic       reset, enable, herstart, sample_valid;
    logic [7:0] huil_vol, hartslag;
    logic [2:0] amp, freq, lost_cnt;
    logic       eval_pulse, restart;

    int total = 0;
    int bad   = 0;

    // reference model state: levels, best average, lost count, axis (0=freq), dir (0=up)
    int m_amp, m_freq, m_best, m_lost, m_axis, m_dir;
    int down_val = 200;

    rock_regulator dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .herstart    (herstart),
        .sample_valid(sample_valid),
        .huil_vol    (huil_vol),
        .hartslag    (hartslag),
        .amp         (amp),
        .freq        (freq),
        .eval_pulse  (eval_pulse),
        .restart     (restart),
        .lost_cnt    (lost_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        sample_valid = 1'b0;
        herstart     = 1'b0;
    endtask

    task automatic garbage;
        sample_valid = 1'b1;
        huil_vol     = 8'($urandom_range(0, 255));
        hartslag     = 8'($urandom_range(0, 255));
    endtask

    task automatic model_restart;
        m_amp = 3; m_freq = 3; m_best = 511; m_lost = 0; m_axis = 0; m_dir = 0;
    endtask

    // One evaluation from the rules: returns 1 when the path is declared lost.
    task automatic model_eval(input int avg, output bit rec);
        int l;
        rec = 1'b0;
        if (avg < m_best) begin
            m_best = avg;
            m_lost = 0;
        end else begin
            m_dir  = 1 - m_dir;
            m_axis = 1 - m_axis;
            m_lost = (avg > m_best + 16) ? m_lost + 1 : 0;
        end
        if (m_lost == 4) begin
            rec = 1'b1;
            model_restart();
        end else begin
            l = m_axis ? m_amp : m_freq;
            if (m_dir == 0) begin
                if (l == 7) begin l = 6; m_dir = 1; end else l = l + 1;
            end else begin
                if (l == 0) begin l = 1; m_dir = 0; end else l = l - 1;
            end
            if (m_axis) m_amp = l; else m_freq = l;
        end
    endtask

    // Feed one full window from S_MEAS and check eval/step/recover outcome.
    // mode 0: fixed hv/rv, 1: fully random, 2: near hv with rv=0
    task automatic run_eval(input int mode, input int hv, input int rv);
        int h, r, sum;
        bit rec;
        sum = 0;
        for (int i = 0; i < 4; i++) begin
            case (mode)
                0:       begin h = hv; r = rv; end
                1:       begin h = $urandom_range(0, 255); r = $urandom_range(0, 255); end
                default: begin h = hv + $urandom_range(0, 3); r = 0; end
            endcase
            sample_valid = 1'b1;
            huil_vol = 8'(h);
            hartslag = 8'(r);
            sum += h + (r >> 1);
            tick();
            idle();
            if (i < 3) begin
                chk("no_eval_early", eval_pulse, 0);
                repeat ($urandom_range(0, 2)) tick();
            end
        end
        chk("eval_pulse", eval_pulse, 1);
        chk("hold_amp", amp, m_amp);
        chk("hold_freq", freq, m_freq);
        garbage();
        model_eval(sum / 4, rec);
        tick();
        chk("eval_end", eval_pulse, 0);
        chk("restart", restart, rec);
        chk("amp", amp, m_amp);
        chk("freq", freq, m_freq);
        chk("lost_cnt", lost_cnt, m_lost);
        garbage();
        tick();
        if (rec) begin
            chk("restart_end", restart, 0);
            garbage();
            tick();
        end
        idle();
    endtask

    initial begin
        reset = 1'b0; enable = 1'b0; herstart = 1'b0; sample_valid = 1'b0;
        huil_vol = '0; hartslag = '0;
        model_restart();
        tick(); tick();
        chk("rst_amp", amp, 3);
        chk("rst_freq", freq, 3);
        chk("rst_eval", eval_pulse, 0);
        chk("rst_restart", restart, 0);
        chk("rst_lost", lost_cnt, 0);
        reset = 1'b1;
        enable = 1'b1;
        tick();

        // avg 60 improves; then avg 70 is worse but within margin
        run_eval(0, 40, 40);
        chk("t2_freq", freq, 4);
        run_eval(0, 50, 40);
        chk("t3_amp", amp, 2);
        chk("t3_lost", lost_cnt, 0);

        // asynchronous reset in the middle of a window
        for (int i = 0; i < 2; i++) begin
            sample_valid = 1'b1; huil_vol = 8'd90; hartslag = 8'd10;
            tick();
        end
        idle();
        reset = 1'b0;
        #1;
        chk("mid_rst_amp", amp, 3);
        chk("mid_rst_freq", freq, 3);
        chk("mid_rst_eval", eval_pulse, 0);
        chk("mid_rst_restart", restart, 0);
        tick();
        reset = 1'b1;
        model_restart();
        tick();
        run_eval(0, 40, 40);

        // external restart, then climb freq into saturation
        herstart = 1'b1;
        tick();
        herstart = 1'b0;
        model_restart();
        chk("hs_restart", restart, 1);
        chk("hs_amp", amp, 3);
        chk("hs_freq", freq, 3);
        tick();
        chk("hs_restart_end", restart, 0);
        tick();
        for (int v = 100; v >= 60; v -= 10) run_eval(0, v, 0);
        chk("sat_freq", freq, 6);

        // four strongly worse windows trigger the automatic restart
        for (int k = 0; k < 4; k++) run_eval(0, 255, 255);
        chk("lost_recover_freq", freq, 3);

        // herstart together with the completing sample: no evaluation, restart instead
        for (int i = 0; i < 4; i++) begin
            sample_valid = 1'b1; huil_vol = 8'd30; hartslag = 8'd30;
            herstart = (i == 3);
            tick();
        end
        idle();
        model_restart();
        chk("hs4_eval", eval_pulse, 0);
        chk("hs4_restart", restart, 1);
        tick(); tick();
        run_eval(0, 40, 40);

        // disable mid-window: partial sum discarded, levels held
        for (int i = 0; i < 2; i++) begin
            sample_valid = 1'b1; huil_vol = 8'd250; hartslag = 8'd250;
            tick();
        end
        enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            garbage();
            tick();
        end
        idle();
        chk("dis_amp", amp, m_amp);
        chk("dis_freq", freq, m_freq);
        chk("dis_lost", lost_cnt, m_lost);
        enable = 1'b1;
        tick();
        run_eval(0, 20, 0);

        // randomized windows
        for (int n = 0; n < 80; n++) begin
            int sel;
            sel = $urandom_range(0, 4);
            if (sel < 2) run_eval(1, 0, 0);
            else if (sel == 2) run_eval(0, 255, 255);
            else begin
                run_eval(2, down_val, 0);
                down_val = (down_val < 10) ? 240 : down_val - 7;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
